// File: rtl/alu_pkg.sv
// Shared ALU dispatch definitions: opcode numbers, dispatcher state encoding and
// the default multi-cycle op mask.
package alu_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_SLL  = 4;
    localparam int unsigned OP_SRA  = 5;
    localparam int unsigned OP_MULT = 6;
    localparam int unsigned OP_DIV  = 7;

    localparam logic [7:0] DEFAULT_MC_MASK = 8'hC0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mc_counter.sv
// Multi-cycle op counter: loads MC_LAT-1 on issue and counts down to zero.
module alu_mc_counter #(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic is_zero_c,
    output logic is_one_c
);

    localparam int unsigned CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CNT_W'(MC_LAT - 1);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_zero_c = (count_q == '0);
    assign is_one_c  = (count_q == CNT_W'(1));

endmodule

// File: rtl/alu_op_dispatch.sv
// Registered ALU opcode dispatcher: one-hot unit enables with valid/ready issue and
// multi-cycle op sequencing. Optional illegal-opcode trap under ALU_ILLEGAL_TRAP_EN.
module alu_op_dispatch
    import alu_pkg::*;
#(
    parameter int unsigned          OPCODE_W = 5,
    parameter int unsigned          NUM_OPS  = 8,
    parameter logic [NUM_OPS-1:0]   MC_MASK  = NUM_OPS'(DEFAULT_MC_MASK),
    parameter int unsigned          MC_LAT   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] ctrl_ALUopcode,
    output logic                in_ready,
    output logic [NUM_OPS-1:0]  op_en,
    output logic                op_valid,
    output logic                op_done,
`ifdef ALU_ILLEGAL_TRAP_EN
    output logic                err_sticky,
    output logic [7:0]          err_count,
`endif
    output logic                illegal
);

    alu_state_e         state_q, state_d;
    logic [NUM_OPS-1:0] op_en_q, op_en_d;
    logic               op_valid_q, op_valid_d;
    logic               op_done_q, op_done_d;
    logic               illegal_q, illegal_d;
    logic [NUM_OPS-1:0] dec_hit;
    logic               accept;
    logic               legal;
    logic               is_mc;
    logic               cnt_load, cnt_dec;
    logic               cnt_zero, cnt_one;

    // Full-width equality per op, so out-of-range opcodes never alias onto a unit.
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_dec
        assign dec_hit[i] = (ctrl_ALUopcode == OPCODE_W'(i));
    end

    assign legal  = |dec_hit;
    assign is_mc  = |(dec_hit & MC_MASK);

`ifdef ALU_ILLEGAL_TRAP_EN
    logic       err_sticky_q, err_sticky_d;
    logic [7:0] err_count_q, err_count_d;

    assign in_ready = (state_q != WAIT) && !err_sticky_q;

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (accept && !legal) begin
            err_sticky_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
`else
    assign in_ready = (state_q != WAIT);
`endif

    assign accept = in_valid && in_ready;

    alu_mc_counter #(
        .MC_LAT (MC_LAT)
    ) u_mc_counter (
        .clock     (clock),
        .reset     (reset),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .is_zero_c (cnt_zero),
        .is_one_c  (cnt_one)
    );

    always_comb begin
        state_d    = state_q;
        op_en_d    = '0;
        op_valid_d = 1'b0;
        op_done_d  = 1'b0;
        illegal_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state_q)
            WAIT: begin
                // Enables stay up until the cycle after op_done, then drop to IDLE.
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    op_en_d    = op_en_q;
                    op_valid_d = 1'b1;
                    op_done_d  = cnt_one;
                    cnt_dec    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                    end else if (is_mc) begin
                        state_d    = WAIT;
                        op_en_d    = dec_hit;
                        op_valid_d = 1'b1;
                        cnt_load   = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        op_en_d    = dec_hit;
                        op_valid_d = 1'b1;
                        op_done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_en_q    <= '0;
            op_valid_q <= 1'b0;
            op_done_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_en_q    <= op_en_d;
            op_valid_q <= op_valid_d;
            op_done_q  <= op_done_d;
            illegal_q  <= illegal_d;
        end
    end

    assign op_en    = op_en_q;
    assign op_valid = op_valid_q;
    assign op_done  = op_done_q;
    assign illegal  = illegal_q;

endmodule
